sec_ded_rd_buffer: RTL

Downstream consumer of the SEC-DED decoder's 96-bit `data_out` and 1-bit `decode_result_out`, where `decode_result_out` = 1 marks a detected uncorrectable error (DUE). The block registers each decoded beat into a small FIFO and presents it to the read-return path over a valid/ready handshake. Each beat carries a poison flag. The block also keeps DUE statistics: a saturating event count, a sticky interrupt, and the sequence number of the first DUE.

---
 rtl/sec_ded_rd_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/sec_ded_rd_buffer.sv
// Read-return buffer behind the SEC-DED decoder. Holds decoded beats with a poison flag in a
// small FIFO and keeps DUE statistics: saturating count, sticky interrupt, first-error sequence.
module sec_ded_rd_buffer #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_due,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_poison,
    output logic [CNT_W-1:0]  due_cnt,
    output logic              due_irq,
    input  logic              irq_clr,
    output logic [CNT_W-1:0]  first_seq
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_seq;
    logic [CNT_W-1:0]   r_due_cnt;
    logic [CNT_W-1:0]   r_first_seq;
    logic               r_due_irq;
    logic               r_armed;

    logic               w_push;
    logic               w_pop;
    logic               w_due_ev;
    logic [ENTRY_W-1:0] w_head;

    // Handshake flags depend on occupancy only, so there is no ready-to-ready path.
    assign in_ready   = (r_count != OCC_W'(DEPTH));
    assign out_valid  = (r_count != OCC_W'(0));
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_due_ev   = w_push && in_due;

    assign w_head     = r_mem[r_rd_ptr];
    assign out_data   = w_head[DATA_W-1:0];
    assign out_poison = w_head[DATA_W];

    assign due_cnt    = r_due_cnt;
    assign due_irq    = r_due_irq;
    assign first_seq  = r_first_seq;

    // Storage array: written only, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_due, in_data};
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + OCC_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - OCC_W'(1);
            end
        end
    end

    // DUE statistics; a DUE accepted in the same cycle as irq_clr wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq       <= '0;
            r_due_cnt   <= '0;
            r_first_seq <= '0;
            r_due_irq   <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            if (w_push) begin
                r_seq <= r_seq + CNT_W'(1);
            end
            if (w_due_ev) begin
                if (r_due_cnt != {CNT_W{1'b1}}) begin
                    r_due_cnt <= r_due_cnt + CNT_W'(1);
                end
                r_due_irq <= 1'b1;
                r_armed   <= 1'b0;
                if (r_armed || irq_clr) begin
                    r_first_seq <= r_seq;
                end
            end else if (irq_clr) begin
                r_due_irq <= 1'b0;
                r_armed   <= 1'b1;
            end
        end
    end

endmodule
